// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - shared state type and default timing for the traffic light controller
package traffic_light_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        AMBER   = 2'd2
    } tl_state_e;

    localparam int DEF_NUM_DIRS     = 2;
    localparam int DEF_CNT_W        = 16;
    localparam int DEF_GREEN_TICS   = 200;
    localparam int DEF_AMBER_TICS   = 30;
    localparam int DEF_ALLRED_TICS  = 5;
    localparam int DEF_PED_EXT_TICS = 50;

endpackage

// File: rtl/traffic_light_if.sv
// rtl/traffic_light_if.sv - timebase, pedestrian and lamp signals of the traffic light controller
interface traffic_light_if #(
    parameter int NUM_DIRS = 2
) ();
    localparam int DIR_W = $clog2(NUM_DIRS);

    logic                tick_en;
    logic                hold;
    logic [NUM_DIRS-1:0] ped_req;
    logic [NUM_DIRS-1:0] red;
    logic [NUM_DIRS-1:0] amber;
    logic [NUM_DIRS-1:0] green;
    logic [NUM_DIRS-1:0] walk;
    logic [DIR_W-1:0]    active_dir;

    modport master (
        output tick_en, hold, ped_req,
        input  red, amber, green, walk, active_dir
    );

    modport slave (
        input  tick_en, hold, ped_req,
        output red, amber, green, walk, active_dir
    );
endinterface

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - phase tick counter; done pulses on the tick that completes len_i ticks
module traffic_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             tick_en_i,
    input  logic             hold_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             clear_i,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step;

    // hold wins over a simultaneous tick
    assign step   = tick_en_i && !hold_i;
    assign done_o = step && (cnt_q == len_i - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (done_o) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - round-robin traffic light FSM with registered lamps
// Optional pedestrian walk/extension enabled by defining TRAFFIC_LIGHT_PED_EN.
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int NUM_DIRS     = DEF_NUM_DIRS,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int GREEN_TICS   = DEF_GREEN_TICS,
    parameter int AMBER_TICS   = DEF_AMBER_TICS,
    parameter int ALLRED_TICS  = DEF_ALLRED_TICS,
    parameter int PED_EXT_TICS = DEF_PED_EXT_TICS
) (
    input  logic           clock,
    input  logic           reset,
    traffic_light_if.slave bus
);
    localparam int               DIR_W      = $clog2(NUM_DIRS);
    localparam logic [DIR_W-1:0] LAST_DIR   = DIR_W'(NUM_DIRS - 1);
    localparam logic [CNT_W-1:0] GREEN_LEN  = CNT_W'(GREEN_TICS);
    localparam logic [CNT_W-1:0] AMBER_LEN  = CNT_W'(AMBER_TICS);
    localparam logic [CNT_W-1:0] ALLRED_LEN = CNT_W'(ALLRED_TICS);

    tl_state_e           state_q, state_d;
    logic [DIR_W-1:0]    dir_q, dir_d;
    logic [NUM_DIRS-1:0] red_q, red_d;
    logic [NUM_DIRS-1:0] amber_q, amber_d;
    logic [NUM_DIRS-1:0] green_q, green_d;
    logic [CNT_W-1:0]    phase_len;
    logic                phase_done;

`ifdef TRAFFIC_LIGHT_PED_EN
    localparam logic [CNT_W-1:0] GREEN_PED_LEN = CNT_W'(GREEN_TICS + PED_EXT_TICS);

    logic [NUM_DIRS-1:0] walk_q, walk_d;
    logic [NUM_DIRS-1:0] latch_q, latch_d;
`else
    logic unused_ped;
    assign unused_ped = ^bus.ped_req;
`endif

    always_comb begin
        phase_len = ALLRED_LEN;
        case (state_q)
`ifdef TRAFFIC_LIGHT_PED_EN
            GREEN:   phase_len = (|walk_q) ? GREEN_PED_LEN : GREEN_LEN;
`else
            GREEN:   phase_len = GREEN_LEN;
`endif
            AMBER:   phase_len = AMBER_LEN;
            default: phase_len = ALLRED_LEN;
        endcase
    end

    traffic_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock     (clock),
        .tick_en_i (bus.tick_en),
        .hold_i    (bus.hold),
        .len_i     (phase_len),
        .clear_i   (reset),
        .done_o    (phase_done)
    );

    // Lamps are decoded from next state so they flip on the same edge as the state
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        if (phase_done) begin
            case (state_q)
                ALL_RED: begin
                    state_d = GREEN;
                    dir_d   = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);
                end
                GREEN:   state_d = AMBER;
                default: state_d = ALL_RED;
            endcase
        end

        red_d   = '1;
        amber_d = '0;
        green_d = '0;
        for (int d = 0; d < NUM_DIRS; d++) begin
            if (DIR_W'(d) == dir_d) begin
                if (state_d == GREEN) begin
                    red_d[d]   = 1'b0;
                    green_d[d] = 1'b1;
                end else if (state_d == AMBER) begin
                    red_d[d]   = 1'b0;
                    amber_d[d] = 1'b1;
                end
            end
        end
    end

`ifdef TRAFFIC_LIGHT_PED_EN
    // A request on the serving edge re-arms the latch for the next green
    always_comb begin
        latch_d = latch_q | bus.ped_req;
        walk_d  = (state_d == GREEN) ? walk_q : '0;
        if (phase_done && state_q == ALL_RED) begin
            for (int d = 0; d < NUM_DIRS; d++) begin
                if (DIR_W'(d) == dir_d && latch_q[d]) begin
                    walk_d[d]  = 1'b1;
                    latch_d[d] = bus.ped_req[d];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            walk_q  <= '0;
            latch_q <= '0;
        end else begin
            walk_q  <= walk_d;
            latch_q <= latch_d;
        end
    end

    assign bus.walk = walk_q;
`else
    assign bus.walk = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ALL_RED;
            dir_q   <= LAST_DIR;
            red_q   <= '1;
            amber_q <= '0;
            green_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            red_q   <= red_d;
            amber_q <= amber_d;
            green_q <= green_d;
        end
    end

    assign bus.red        = red_q;
    assign bus.amber      = amber_q;
    assign bus.green      = green_q;
    assign bus.active_dir = dir_q;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - scoreboard bench for traffic_light_ctrl
module tb_traffic_light_ctrl;
    localparam int ND = 3;

    typedef struct packed {
        logic [1:0] dir;
        logic [2:0] r;
        logic [2:0] a;
        logic [2:0] g;
        logic [2:0] w;
    } pat_t;

    typedef struct {
        pat_t pat;
        int   len;
    } seg_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   chk_on = 1'b0;
    int   tick_mode = 0;
    seg_t exp_q[$];

    always #5 clock = ~clock;

    traffic_light_if #(.NUM_DIRS(ND)) tif ();

    traffic_light_ctrl #(
        .NUM_DIRS     (ND),
        .CNT_W        (16),
        .GREEN_TICS   (4),
        .AMBER_TICS   (2),
        .ALLRED_TICS  (1),
        .PED_EXT_TICS (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (tif)
    );

    function automatic seg_t mk(input int d, input int kind, input int len, input logic [2:0] w);
        seg_t       s;
        logic [2:0] oh;
        oh        = 3'(1 << d);
        s.pat.dir = 2'(d);
        s.pat.r   = (kind == 0) ? 3'b111 : ~oh;
        s.pat.a   = (kind == 2) ? oh : 3'b000;
        s.pat.g   = (kind == 1) ? oh : 3'b000;
        s.pat.w   = w;
        s.len     = len;
        return s;
    endfunction

    function automatic seg_t sr(input int d, input int len);
        return mk(d, 0, len, 3'b000);
    endfunction
    function automatic seg_t sg(input int d, input int len, input logic [2:0] w);
        return mk(d, 1, len, w);
    endfunction
    function automatic seg_t sa(input int d, input int len);
        return mk(d, 2, len, 3'b000);
    endfunction

    // Timebase: steady ticks, or one tick every third cycle
    initial begin
        int k;
        k = 0;
        tif.tick_en = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            k++;
            tif.tick_en = (tick_mode == 0) ? 1'b1 : (k % 3 == 0);
        end
    end

    // Segment monitor: a segment is a run of identical lamp/direction patterns
    initial begin
        pat_t obs;
        pat_t cur_pat;
        int   cur_len;
        bit   cur_valid;
        seg_t e;
        cur_valid = 1'b0;
        cur_len   = 0;
        cur_pat   = '0;
        forever begin
            @(negedge clock);
            obs = {tif.active_dir, tif.red, tif.amber, tif.green, tif.walk};
            if (chk_on) begin
                for (int d = 0; d < ND; d++) begin
                    total++;
                    assert ($countones({tif.red[d], tif.amber[d], tif.green[d]}) == 1)
                    else begin
                        bad++;
                        $error("FAIL one_lamp dir=%0d obs_rag=%b exp=one-hot", d, {tif.red[d], tif.amber[d], tif.green[d]});
                    end
                end
                total++;
                assert ($countones(~tif.red) <= 1)
                else begin
                    bad++;
                    $error("FAIL one_nonred obs_red=%b exp=at most one zero", tif.red);
                end
            end
            if (cur_valid && obs !== cur_pat) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    total++;
                    assert (cur_pat === e.pat)
                    else begin
                        bad++;
                        $error("FAIL seg_pat obs=%h exp=%h", cur_pat, e.pat);
                    end
                    if (e.len > 0) begin
                        total++;
                        assert (cur_len === e.len)
                        else begin
                            bad++;
                            $error("FAIL seg_len pat=%h obs=%0d exp=%0d", cur_pat, cur_len, e.len);
                        end
                    end
                end
                cur_valid = 1'b0;
            end
            if (reset) begin
                cur_valid = 1'b0;
            end else if (!cur_valid) begin
                cur_pat   = obs;
                cur_len   = 1;
                cur_valid = 1'b1;
            end else begin
                cur_len++;
            end
        end
    end

    task automatic rst_on();
        @(negedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic rst_off();
        #1 reset = 1'b0;
    endtask

    task automatic wait_green(input logic [2:0] g);
        int n;
        n = 0;
        while (tif.green !== g && n < 200) begin
            @(negedge clock);
            n++;
        end
        total++;
        assert (tif.green === g)
        else begin
            bad++;
            $error("FAIL wait_green obs=%b exp=%b", tif.green, g);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        total++;
        assert (exp_q.size() == 0)
        else begin
            bad++;
            $error("FAIL drain left=%0d exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        tif.hold    = 1'b0;
        tif.ped_req = '0;
        repeat (2) @(posedge clock);
        #1 chk_on = 1'b1;

        @(negedge clock);
        total++;
        assert ({tif.red, tif.amber, tif.green, tif.walk} === 12'b111_000_000_000)
        else begin
            bad++;
            $error("FAIL reset_lamps obs=%b exp=%b", {tif.red, tif.amber, tif.green, tif.walk}, 12'b111_000_000_000);
        end
        total++;
        assert (tif.active_dir === 2'd2)
        else begin
            bad++;
            $error("FAIL reset_dir obs=%0d exp=2", tif.active_dir);
        end

        // Full rotation with wrap back to direction 0
        rst_on();
        exp_q.push_back(sr(2, 1));
        for (int d = 0; d < 3; d++) begin
            exp_q.push_back(sg(d, 4, 3'b000));
            exp_q.push_back(sa(d, 2));
            exp_q.push_back(sr(d, 1));
        end
        exp_q.push_back(sg(0, 4, 3'b000));
        rst_off();
        wait_drain(100);

        // Tick every third cycle
        rst_on();
        tick_mode = 1;
        exp_q.push_back(sr(2, 0));
        exp_q.push_back(sg(0, 12, 3'b000));
        exp_q.push_back(sa(0, 6));
        exp_q.push_back(sr(0, 3));
        exp_q.push_back(sg(1, 12, 3'b000));
        rst_off();
        wait_drain(200);
        tick_mode = 0;

        // Hold for five cycles mid-green with tick still high
        rst_on();
        exp_q.push_back(sr(2, 1));
        exp_q.push_back(sg(0, 9, 3'b000));
        exp_q.push_back(sa(0, 2));
        exp_q.push_back(sr(0, 1));
        exp_q.push_back(sg(1, 4, 3'b000));
        rst_off();
        wait_green(3'b001);
        @(posedge clock);
        #1 tif.hold = 1'b1;
        repeat (5) @(posedge clock);
        #1 tif.hold = 1'b0;
        wait_drain(100);

        // Reset on the third green cycle of direction 1
        rst_on();
        exp_q.push_back(sr(2, 1));
        exp_q.push_back(sg(0, 4, 3'b000));
        exp_q.push_back(sa(0, 2));
        exp_q.push_back(sr(0, 1));
        exp_q.push_back(sg(1, 3, 3'b000));
        exp_q.push_back(sr(2, 1));
        exp_q.push_back(sg(0, 4, 3'b000));
        rst_off();
        wait_green(3'b010);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        total++;
        assert ({tif.red, tif.amber, tif.green} === 9'b111_000_000)
        else begin
            bad++;
            $error("FAIL abort_red obs=%b exp=%b", {tif.red, tif.amber, tif.green}, 9'b111_000_000);
        end
        wait_drain(100);

        // Pedestrian request for direction 2 during direction 0 green
        rst_on();
        exp_q.push_back(sr(2, 1));
        exp_q.push_back(sg(0, 4, 3'b000));
        exp_q.push_back(sa(0, 2));
        exp_q.push_back(sr(0, 1));
        exp_q.push_back(sg(1, 4, 3'b000));
        exp_q.push_back(sa(1, 2));
        exp_q.push_back(sr(1, 1));
`ifdef TRAFFIC_LIGHT_PED_EN
        exp_q.push_back(sg(2, 7, 3'b100));
`else
        exp_q.push_back(sg(2, 4, 3'b000));
`endif
        exp_q.push_back(sa(2, 2));
        exp_q.push_back(sr(2, 1));
        exp_q.push_back(sg(0, 4, 3'b000));
        exp_q.push_back(sa(0, 2));
        exp_q.push_back(sr(0, 1));
        exp_q.push_back(sg(1, 4, 3'b000));
        exp_q.push_back(sa(1, 2));
        exp_q.push_back(sr(1, 1));
        exp_q.push_back(sg(2, 4, 3'b000));
        rst_off();
        wait_green(3'b001);
        @(posedge clock);
        #1 tif.ped_req = 3'b100;
        @(posedge clock);
        #1 tif.ped_req = 3'b000;
        wait_drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter NUM_DIRS, default 2: number of approaches served round-robin; legal range 2..8.
REQ-002 Parameter CNT_W, default 16: phase counter width.
REQ-003 Parameter GREEN_TICS, default 200: green phase length in tick_en pulses; legal range 1..2^CNT_W-1.
REQ-004 Parameter AMBER_TICS, default 30: amber phase length in tick_en pulses; legal range 1..2^CNT_W-1.
REQ-005 Parameter ALLRED_TICS, default 5: all-red clearance length in tick_en pulses; legal range 1..2^CNT_W-1.
REQ-006 Parameter PED_EXT_TICS, default 50: green extension when a walk is served.
REQ-007 clock  input  1  single clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 tick_en  input  1  timebase strobe; one pulse advances the phase count by one.
REQ-010 hold  input  1  freezes the phase counter and the FSM while high.
REQ-011 ped_req  input  NUM_DIRS  per-direction pedestrian request pulse.
REQ-012 red  output  NUM_DIRS  per-direction red lamp.
REQ-013 amber  output  NUM_DIRS  per-direction amber lamp.
REQ-014 green  output  NUM_DIRS  per-direction green lamp.
REQ-015 walk  output  NUM_DIRS  per-direction walk lamp.
REQ-016 active_dir  output  $clog2(NUM_DIRS)  index of the direction currently being served.

Function
REQ-017 The FSM SHALL have the states ALL_RED, GREEN and AMBER, with transitions ALL_RED->GREEN->AMBER->ALL_RED.
REQ-018 The ALL_RED->GREEN transition SHALL advance active_dir by one, wrapping NUM_DIRS-1 to 0; the first GREEN after reset SHALL serve direction 0.
REQ-019 A phase of length L SHALL end after exactly L tick_en pulses: the counter increments on tick_en; when the counter equals L-1 and tick_en is high, the state changes on that edge and the counter clears.
REQ-020 Lamp outputs and walk SHALL be registered and SHALL change on the same edge as the state.
REQ-021 In every cycle, each direction SHALL have exactly one of red, amber or green high.
REQ-022 At most one direction SHALL be non-red; in ALL_RED every direction SHALL be red.
REQ-023 When hold is high, the counter, state and active_dir SHALL not change, and hold SHALL win over a simultaneous tick_en.
REQ-024 Cycles without tick_en SHALL leave the counter unchanged.

Reset
REQ-025 While reset is high, the block SHALL drive: state ALL_RED, counter 0, active_dir NUM_DIRS-1 (so that the first advance selects 0), red all ones, amber/green/walk all zero, and the ped latches cleared.
REQ-026 Reset asserted mid-phase SHALL abort the phase on the next edge, with no amber step.
REQ-027 After reset deasserts, the block SHALL spend ALLRED_TICS tick_en pulses in ALL_RED before green on direction 0.

Configuration
REQ-028 With macro TRAFFIC_LIGHT_PED_EN defined, ped_req[d] SHALL set a sticky latch for direction d.
REQ-029 With TRAFFIC_LIGHT_PED_EN defined, on entering GREEN for direction d with latch[d] set, the block SHALL assert walk[d] for the whole green, lengthen the green to GREEN_TICS+PED_EXT_TICS, and clear latch[d] on that edge.
REQ-030 With TRAFFIC_LIGHT_PED_EN defined, a ped_req[d] arriving during d's green SHALL latch for d's next green, and ped_req on the clearing edge SHALL win over the clear.
REQ-031 Without TRAFFIC_LIGHT_PED_EN, ped_req SHALL be ignored, walk SHALL be tied to 0, no latch logic SHALL exist, and green SHALL always last GREEN_TICS.

Structure
REQ-032 Package traffic_light_pkg SHALL hold the state typedef (ALL_RED, GREEN, AMBER) and the default timing constants.
REQ-033 Sub-module traffic_phase_timer SHALL implement the CNT_W counter (inputs tick_en, hold, load length, clear; output done); the top SHALL hold the FSM, direction pointer, lamp decode and ped latches.

Verification
REQ-034 The bench SHALL run with NUM_DIRS=3, GREEN_TICS=4, AMBER_TICS=2, ALLRED_TICS=1, PED_EXT_TICS=3 and tick_en held at 1 unless stated.
REQ-035 Reset release -> 1 cycle all red, then green=001 for 4 cycles, amber=001 for 2, all red for 1, green=010; green follows 001,010,100,001 (wrap checked).
REQ-036 tick_en pulsed every 3rd cycle -> green lasts 12 cycles and amber 6.
REQ-037 hold high for 5 cycles mid-green -> green lasts 9 cycles; tick_en and hold asserted together do not advance the counter.
REQ-038 Reset pulsed on the 3rd green cycle of direction 1 -> next cycle red=111 with no amber; green resumes on direction 0.
REQ-039 With TRAFFIC_LIGHT_PED_EN, ped_req[2] during direction 0 green -> direction 2 green lasts 7 cycles with walk=100 throughout, and its following green lasts 4 cycles with walk=000.
REQ-040 Throughout all scenarios, assertions SHALL check REQ-021 and REQ-022 every cycle.
